// File: rtl/frame_reg_pkg.sv
// rtl/frame_reg_pkg.sv - shared types and sizing helpers for the frame register bank
package frame_reg_pkg;

  localparam int MAX_NCH = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } fill_state_e;

  // Index width that never collapses to zero bits, even for a single channel.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) >= n) r = i;
    end
    return r;
  endfunction

  function automatic int ch_idx_w(input int nch);
    return clog2_safe(nch);
  endfunction

  function automatic logic [MAX_NCH-1:0] full_mask(input int nch);
    return (MAX_NCH'(1) << nch) - MAX_NCH'(1);
  endfunction

endpackage

// File: rtl/chan_shadow_reg.sv
// rtl/chan_shadow_reg.sv - one channel of the shadow bank, loaded on write enable
module chan_shadow_reg #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/frame_reg_bank.sv
// rtl/frame_reg_bank.sv - double-buffered channel bank; samples fill a shadow bank, full frames move atomically to the output
// Optional FRAME_REG_AUTOINC_EN: an internal write pointer replaces in_ch for channel selection.
module frame_reg_bank
  import frame_reg_pkg::*;
#(
  parameter int NCH   = 31,
  parameter int W     = 21,
  parameter int CNT_W = 8,
  localparam int CH_IDX_W = ch_idx_w(NCH)
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                in_valid,
  input  logic [CH_IDX_W-1:0] in_ch,
  input  logic [W-1:0]        in_data,
  input  logic                in_sof,
  input  logic                frame_ack,
  output logic [NCH*W-1:0]    ch_x_lin,
  output logic                frame_valid,
  output logic [NCH-1:0]      ch_loaded,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                overrun,
  output logic                err_idx
);

  localparam logic [NCH-1:0] FULL_MASK = NCH'(full_mask(NCH));

  fill_state_e         state_q, state_d;
  logic [NCH-1:0]      ch_loaded_q, ch_loaded_d;
  logic [NCH*W-1:0]    ch_x_lin_q, ch_x_lin_d;
  logic                frame_valid_q, frame_valid_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic                err_idx_q, err_idx_d;

  logic [CH_IDX_W-1:0] wr_idx;
  logic                idx_ok;
  logic                wr_en;
  logic                complete;
  logic [NCH-1:0]      wr_onehot;
  logic [NCH-1:0]      mask_base;
  logic [NCH*W-1:0]    shadow_q;
  logic [NCH*W-1:0]    shadow_next;

  assign wr_en     = in_valid && idx_ok;
  assign wr_onehot = wr_en ? (NCH'(1) << wr_idx) : '0;
  // A start-of-frame write discards whatever partial frame was collected.
  assign mask_base = (state_q == EMPTY || in_sof) ? '0 : ch_loaded_q;

`ifdef FRAME_REG_AUTOINC_EN
  logic [CH_IDX_W-1:0] ptr_q, ptr_d;
  logic                unused_in_ch;

  assign unused_in_ch = ^in_ch;
  assign idx_ok       = 1'b1;
  assign wr_idx       = in_sof ? '0 : ptr_q;
  assign complete     = wr_en && (in_sof ? (NCH == 1) : (ptr_q == CH_IDX_W'(NCH - 1)));

  always_comb begin
    ptr_d = ptr_q;
    if (wr_en) begin
      if (complete)    ptr_d = '0;
      else if (in_sof) ptr_d = CH_IDX_W'(1);
      else             ptr_d = ptr_q + CH_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) ptr_q <= '0;
    else              ptr_q <= ptr_d;
  end
`else
  assign idx_ok   = int'(in_ch) < NCH;
  assign wr_idx   = in_ch;
  assign complete = wr_en && ((mask_base | wr_onehot) == FULL_MASK);
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_shadow_reg #(.W(W)) u_shadow (
      .clk    (clk),
      .resetn (GlobalReset),
      .we     (wr_onehot[k]),
      .d      (in_data),
      .q      (shadow_q[k*W +: W])
    );
    // The completing sample lands in the output bank on the same edge.
    assign shadow_next[k*W +: W] = wr_onehot[k] ? in_data : shadow_q[k*W +: W];
  end

  always_comb begin
    state_d       = state_q;
    ch_loaded_d   = ch_loaded_q;
    ch_x_lin_d    = ch_x_lin_q;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_d     = overrun_q;
    err_idx_d     = err_idx_q;

    if (in_valid && !idx_ok) err_idx_d = 1'b1;
    if (frame_ack) frame_valid_d = 1'b0;

    if (complete) begin
      state_d       = EMPTY;
      ch_loaded_d   = '0;
      ch_x_lin_d    = shadow_next;
      frame_valid_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      if (frame_valid_q && !frame_ack) overrun_d = 1'b1;
    end else if (wr_en) begin
      state_d     = FILL;
      ch_loaded_d = mask_base | wr_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_q       <= EMPTY;
      ch_loaded_q   <= '0;
      ch_x_lin_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      err_idx_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_loaded_q   <= ch_loaded_d;
      ch_x_lin_q    <= ch_x_lin_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
      err_idx_q     <= err_idx_d;
    end
  end

  assign ch_x_lin    = ch_x_lin_q;
  assign frame_valid = frame_valid_q;
  assign ch_loaded   = ch_loaded_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_frame_reg_bank.sv
// tb/tb_frame_reg_bank.sv - scoreboard bench for frame_reg_bank
module tb_frame_reg_bank;

  localparam int NCH      = 31;
  localparam int W        = 21;
  localparam int CNT_W    = 8;
  localparam int CH_IDX_W = 5;
  localparam int BW       = NCH * W;

  typedef struct {
    logic [BW-1:0]    bank;
    logic [CNT_W-1:0] cnt;
    logic             ovr;
    logic             fv;
  } exp_t;

  logic                clk = 1'b0;
  logic                GlobalReset = 1'b0;
  logic                in_valid = 1'b0;
  logic [CH_IDX_W-1:0] in_ch = '0;
  logic [W-1:0]        in_data = '0;
  logic                in_sof = 1'b0;
  logic                frame_ack = 1'b0;
  logic [BW-1:0]       ch_x_lin;
  logic                frame_valid;
  logic [NCH-1:0]      ch_loaded;
  logic [CNT_W-1:0]    frame_cnt;
  logic                overrun;
  logic                err_idx;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [W-1:0] mdl [NCH];

  frame_reg_bank #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .in_valid    (in_valid),
    .in_ch       (in_ch),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .frame_ack   (frame_ack),
    .ch_x_lin    (ch_x_lin),
    .frame_valid (frame_valid),
    .ch_loaded   (ch_loaded),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .err_idx     (err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_mdl();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < NCH; k++) b[k*W +: W] = mdl[k];
    return b;
  endfunction

  // Drive one cycle of a valid write; returns #1 after the sampling edge.
  task automatic wr(input int ch, input int data, input bit sof, input bit ack);
    @(negedge clk);
    in_valid  = 1'b1;
    in_ch     = CH_IDX_W'(ch);
    in_data   = W'(data);
    in_sof    = sof;
    frame_ack = ack;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    frame_ack = 1'b0;
    if (ch < NCH) mdl[ch] = W'(data);
  endtask

  task automatic ack_cycle();
    @(negedge clk);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
  endtask

  task automatic push_exp(input int cnt, input bit ovr);
    exp_t e;
    e.bank = pack_mdl();
    e.cnt  = CNT_W'(cnt);
    e.ovr  = ovr;
    e.fv   = 1'b1;
    exp_q.push_back(e);
  endtask

  // Writes channels first..NCH-1 with base+k; the last write completes the frame.
  task automatic fill(input int first, input int base, input bit ack_last, input int cnt, input bit ovr);
    for (int k = first; k < NCH; k++) wr(k, base + k, 1'b0, (k == NCH - 1) && ack_last);
    push_exp(cnt, ovr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ch_x_lin"}, ch_x_lin, '0);
    chk({tag, "_frame_valid"}, BW'(frame_valid), '0);
    chk({tag, "_ch_loaded"}, BW'(ch_loaded), '0);
    chk({tag, "_frame_cnt"}, BW'(frame_cnt), '0);
    chk({tag, "_overrun"}, BW'(overrun), '0);
    chk({tag, "_err_idx"}, BW'(err_idx), '0);
  endtask

  // Monitor: every increment of frame_cnt is a completed frame to score.
  initial begin : monitor
    logic [CNT_W-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (frame_cnt == CNT_W'(prev + 1'b1)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion actual=frame_cnt %0d required=no completion", frame_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("mon_ch_x_lin", ch_x_lin, e.bank);
          chk("mon_frame_cnt", BW'(frame_cnt), BW'(e.cnt));
          chk("mon_frame_valid", BW'(frame_valid), BW'(e.fv));
          chk("mon_overrun", BW'(overrun), BW'(e.ovr));
        end
      end
      prev = frame_cnt;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int k = 0; k < NCH; k++) mdl[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_idle");

    // Frame A: data k+1, check mid-frame stability and 1-cycle latency.
    for (int k = 0; k < NCH - 1; k++) wr(k, k + 1, 1'b0, 1'b0);
    chk("a_mask_before_last", BW'(ch_loaded), BW'(31'h3FFF_FFFF));
    chk("a_fv_before_last", BW'(frame_valid), '0);
    chk("a_out_unchanged_mid", ch_x_lin, '0);
    wr(NCH - 1, NCH, 1'b0, 1'b0);
    push_exp(1, 1'b0);
    chk("a_fv_latency", BW'(frame_valid), BW'(1'b1));
    chk("a_mask_cleared", BW'(ch_loaded), '0);
    chk("a_slot30", BW'(ch_x_lin[30*W +: W]), BW'(31));
    ack_cycle();
    chk("a_ack_clears_fv", BW'(frame_valid), '0);

    // Frame B: duplicate channel 5, last value wins.
    wr(5, 'h1AAAA, 1'b0, 1'b0);
    for (int k = 0; k < NCH; k++) wr(k, (k == 5) ? 'h05555 : ('h100 + k), 1'b0, 1'b0);
    push_exp(2, 1'b0);
    chk("b_slot5", BW'(ch_x_lin[5*W +: W]), BW'(21'h05555));
    ack_cycle();

    // Frame C: partial frame dropped by in_sof.
    for (int k = 0; k < 10; k++) wr(k, 'h200 + k, 1'b0, 1'b0);
    wr(0, 7, 1'b1, 1'b0);
    chk("c_sof_mask", BW'(ch_loaded), BW'(1));
    fill(1, 'h300, 1'b0, 3, 1'b0);
    @(negedge clk);
    chk("c_single_completion", BW'(frame_cnt), BW'(3));
    chk("c_slot0", BW'(ch_x_lin[W-1:0]), BW'(7));
    ack_cycle();

    // Frames D, E without ack, then F completing with ack in the same cycle.
    fill(0, 'h400, 1'b0, 4, 1'b0);
    fill(0, 'h500, 1'b0, 5, 1'b1);
    fill(0, 'h600, 1'b1, 6, 1'b1);
    @(negedge clk);
    chk("f_fv_stays", BW'(frame_valid), BW'(1'b1));

    // Invalid index, then reset mid-frame.
    for (int k = 0; k < 3; k++) wr(k, 'h700 + k, 1'b0, 1'b0);
    wr(31, 'h1FFFF, 1'b0, 1'b0);
    chk("err_idx_set", BW'(err_idx), BW'(1'b1));
    chk("err_mask_unchanged", BW'(ch_loaded), BW'(3'b111));
    chk("err_out_unchanged", BW'(ch_x_lin[W-1:0]), BW'(21'h600));
    @(negedge clk);
    GlobalReset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("mid_reset");
    GlobalReset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", BW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_reg_bank.md
Name: frame_reg_bank

Overview:
- Parametrised, double-buffered channel register bank; the next generation of the per-channel enable-register array for the linearised channel samples (ch*_x_lin).
- A binary channel index with a valid strobe replaces the one-hot enables. Incoming samples fill a shadow bank.
- When every channel has been written, the whole frame transfers atomically to the output bank and frame_valid is raised, held until downstream acknowledges it.
- Sits between the per-sample linearisation datapath and the frame-level consumer.

Parameters:
- NCH, 31, number of channels (2..64)
- W, 21, sample width in bits
- CNT_W, 8, completed-frame counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- GlobalReset  in  1  synchronous, active-low reset
- in_valid  in  1  sample strobe
- in_ch  in  CH_IDX_W  target channel index, CH_IDX_W = $clog2(NCH)
- in_data  in  W  sample value
- in_sof  in  1  start of frame, qualified by in_valid
- frame_ack  in  1  consumer has taken the current frame
- ch_x_lin  out  NCH*W  output bank; channel k occupies bits [k*W +: W]
- frame_valid  out  1  complete frame present, not yet acknowledged
- ch_loaded  out  NCH  shadow-bank written-channel mask
- frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W
- overrun  out  1  sticky: a frame completed while the previous one was unacknowledged
- err_idx  out  1  sticky: in_valid seen with in_ch >= NCH

Behaviour:
- Reset (GlobalReset==0 at a clk edge): shadow bank, ch_x_lin, ch_loaded, frame_cnt = 0; frame_valid, overrun, err_idx = 0. Reset overrides all other inputs; a partial frame is discarded.
- FSM, derived from mask and frame_valid:
  - EMPTY (mask==0) -> FILL on a valid write.
  - FILL -> EMPTY on completion.
  - The frame_valid flag is orthogonal to these states.
- Write: when in_valid && in_ch<NCH, shadow[in_ch]<=in_data and ch_loaded[in_ch]<=1.
- Duplicate writes to the same channel within a frame: last value wins; the mask bit stays 1.
- Invalid index: in_valid && in_ch>=NCH -> write ignored, err_idx<=1. Cleared only by reset.
- in_sof with in_valid: the mask is cleared, then only the current channel bit is set. The partial frame is dropped without error. in_sof without in_valid is ignored.
- Completion: the write cycle where (mask | onehot(in_ch)) == all-ones. On the next edge:
  - ch_x_lin <= shadow, including the completing sample.
  - ch_loaded <= 0.
  - frame_valid <= 1.
  - frame_cnt <= frame_cnt+1.
  - Latency is 1 cycle from the completing write to the output update.
- ch_x_lin changes only on completion or reset, never mid-frame.
- frame_ack clears frame_valid on the next edge; an ack while frame_valid==0 has no effect.
- Completion coinciding with frame_ack: frame_valid stays 1 and overrun is not set.
- Completion while frame_valid==1 and no ack: the output is still overwritten and overrun<=1.
- NCH==1: every valid write completes a frame.

Optional Feature:
- Macro: FRAME_REG_AUTOINC_EN.
- When defined:
  - in_ch is ignored. An internal write pointer (CH_IDX_W bits) selects the channel.
  - The pointer is 0 after reset, completion, or in_sof, and increments on each valid write.
  - On a valid in_sof write the sample goes to channel 0 and the pointer becomes 1.
  - Completion occurs on the write with pointer==NCH-1, and the pointer wraps to 0.
  - err_idx is tied to 0.
- When undefined: behaviour exactly as above and no pointer register exists.

Decomposition:
- Package frame_reg_pkg: function clog2_safe(n) (returns >=1), localparam helpers for CH_IDX_W and the all-ones mask, and a state typedef enum {EMPTY, FILL}.
- One natural sub-module, chan_shadow_reg: a single W-bit shadow register with write enable and synchronous active-low clear, instantiated NCH times via generate.
- The output bank, mask, counter and flags stay in the top level.

Test Plan:
- Reset then idle: all outputs = 0.
- Fill NCH=31 channels in order 0..30 with data=k+1: frame_valid rises one cycle after the ch30 write; ch_x_lin slot k = k+1; frame_cnt=1; ch_loaded=0.
- Write ch5=0x1AAAA then ch5=0x05555 within a frame, then complete: slot 5 = 0x05555.
- Write ch 0..9, assert in_sof with ch0=7, then write ch1..30: exactly one completion; slot 0 = 7; overrun=0.
- Complete two frames without frame_ack: overrun=1, ch_x_lin = second frame. Then complete a frame with frame_ack in the completion cycle: frame_valid stays 1.
- in_valid with in_ch=31: err_idx=1, ch_loaded unchanged. Assert GlobalReset=0 mid-frame: all cleared next edge.
